// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-controller bus: decode controls, PC_LUT lookup pair and PC outputs.
// Perf-counter signals exist only when BRANCH_PERF_EN is defined.
interface pc_fetch_ctrl_if #(
   parameter int unsigned PC_WIDTH   = 12,
   parameter int unsigned PERF_WIDTH = 16
) ();

   logic                start_i;
   logic                halt_i;
   logic                stall_i;
   logic                branch_i;
   logic [3:0]          jump_index_i;
   logic [3:0]          lut_index_o;
   logic [PC_WIDTH-1:0] lut_target_i;
   logic [PC_WIDTH-1:0] pc_o;
   logic                pc_valid_o;
   logic                halted_o;

`ifdef BRANCH_PERF_EN
   logic [PERF_WIDTH-1:0] branch_cnt_o;
   logic [PERF_WIDTH-1:0] stall_cnt_o;
`else
   if (PERF_WIDTH == 0) begin : g_perf_width_chk
      $error("PERF_WIDTH must be nonzero");
   end
`endif

   // Decode / LUT side.
   modport master (
      output start_i,
      output halt_i,
      output stall_i,
      output branch_i,
      output jump_index_i,
      output lut_target_i,
      input  lut_index_o,
      input  pc_o,
      input  pc_valid_o,
      input  halted_o
`ifdef BRANCH_PERF_EN
      ,
      input  branch_cnt_o,
      input  stall_cnt_o
`endif
   );

   // Fetch controller side.
   modport slave (
      input  start_i,
      input  halt_i,
      input  stall_i,
      input  branch_i,
      input  jump_index_i,
      input  lut_target_i,
      output lut_index_o,
      output pc_o,
      output pc_valid_o,
      output halted_o
`ifdef BRANCH_PERF_EN
      ,
      output branch_cnt_o,
      output stall_cnt_o
`endif
   );

endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC register and fetch sequencer (IDLE/RUN/HALT) driving the PC_LUT branch-target table.
// Optional saturating branch/stall counters when BRANCH_PERF_EN is defined.
module pc_fetch_ctrl #(
   parameter int unsigned         PC_WIDTH   = 12,
   parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
   parameter int unsigned         PERF_WIDTH = 16
) (
   input logic            clk,
   input logic            rst_n,
   pc_fetch_ctrl_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

   localparam logic [PC_WIDTH-1:0] PcOne = {{(PC_WIDTH-1){1'b0}}, 1'b1};

   state_e              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic                pc_valid_q, pc_valid_d;
   logic                halted_q, halted_d;

   // Lookup and PC update share the cycle, so the index is a plain pass-through.
   assign bus.lut_index_o = bus.jump_index_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (bus.start_i) state_d = StRun;
         StRun:   if (bus.halt_i)  state_d = StHalt;
         StHalt:  if (bus.start_i) state_d = StRun;
         default: state_d = StIdle;
      endcase
   end

   // lut_target_i is only selected on an applied branch so an idle X cannot leak.
   always_comb begin
      pc_d = pc_q;
      unique case (state_q)
         StIdle: pc_d = RESET_PC;
         StRun: begin
            if (bus.halt_i || bus.stall_i) begin
               pc_d = pc_q;
            end else if (bus.branch_i) begin
               pc_d = bus.lut_target_i;
            end else begin
               pc_d = pc_q + PcOne;
            end
         end
         StHalt:  if (bus.start_i) pc_d = RESET_PC;
         default: pc_d = RESET_PC;
      endcase
      pc_valid_d = (state_d == StRun);
      halted_d   = (state_d == StHalt);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         pc_valid_q <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         pc_valid_q <= pc_valid_d;
         halted_q   <= halted_d;
      end
   end

   assign bus.pc_o       = pc_q;
   assign bus.pc_valid_o = pc_valid_q;
   assign bus.halted_o   = halted_q;

`ifdef BRANCH_PERF_EN
   localparam logic [PERF_WIDTH-1:0] CntOne = {{(PERF_WIDTH-1){1'b0}}, 1'b1};

   logic                  branch_take;
   logic                  stall_take;
   logic [PERF_WIDTH-1:0] branch_cnt_q;
   logic [PERF_WIDTH-1:0] stall_cnt_q;

   assign branch_take = (state_q == StRun) && !bus.halt_i && !bus.stall_i && bus.branch_i;
   assign stall_take  = (state_q == StRun) && !bus.halt_i && bus.stall_i;

   // Counters survive a restart; only rst_n clears them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_cnt_q <= '0;
         stall_cnt_q  <= '0;
      end else begin
         if (branch_take && !(&branch_cnt_q)) branch_cnt_q <= branch_cnt_q + CntOne;
         if (stall_take && !(&stall_cnt_q))   stall_cnt_q  <= stall_cnt_q + CntOne;
      end
   end

   assign bus.branch_cnt_o = branch_cnt_q;
   assign bus.stall_cnt_o  = stall_cnt_q;
`else
   if (PERF_WIDTH == 0) begin : g_perf_width_chk
      $error("PERF_WIDTH must be nonzero");
   end
`endif

`ifndef SYNTHESIS
   a_valid_halt_excl: assert property (@(posedge clk) disable iff (!rst_n)
      !(pc_valid_q && halted_q));
   a_idle_pc: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == StIdle) |-> (pc_q == RESET_PC && !pc_valid_q));
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed, table-driven bench for pc_fetch_ctrl with a small PC_LUT model.
// Counter checks are compiled in only when BRANCH_PERF_EN is defined.
module tb_pc_fetch_ctrl;

   localparam int unsigned PW = 4;

   typedef struct {
      logic        start;
      logic        halt;
      logic        stall;
      logic        branch;
      logic [3:0]  jidx;
      logic [11:0] pc;
      logic        valid;
      logic        halted;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pc_fetch_ctrl_if #(.PC_WIDTH(12), .PERF_WIDTH(PW)) bus ();

   pc_fetch_ctrl #(
      .PC_WIDTH   (12),
      .RESET_PC   (12'h000),
      .PERF_WIDTH (PW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [11:0] lut_mem [16];
   logic        lut_x;
   assign bus.lut_target_i = lut_x ? 12'hxxx : lut_mem[bus.lut_index_o];

   int total = 0;
   int bad = 0;
   vec_t vecs [31];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic s, input logic h, input logic st, input logic b,
                               input logic [3:0] j, input logic [11:0] pc, input logic v,
                               input logic hl);
      vec_t r;
      r.start = s; r.halt = h; r.stall = st; r.branch = b;
      r.jidx = j; r.pc = pc; r.valid = v; r.halted = hl;
      return r;
   endfunction

   task automatic apply(input vec_t v, input string tag);
      bus.start_i      = v.start;
      bus.halt_i       = v.halt;
      bus.stall_i      = v.stall;
      bus.branch_i     = v.branch;
      bus.jump_index_i = v.jidx;
      lut_x            = !(v.branch && !v.stall && !v.halt);
      #1;
      if (v.branch) chk({tag, " lut_index"}, 32'(bus.lut_index_o), 32'(v.jidx));
      @(posedge clk);
      #1;
      chk({tag, " pc"}, 32'(bus.pc_o), 32'(v.pc));
      chk({tag, " valid"}, 32'(bus.pc_valid_o), 32'(v.valid));
      chk({tag, " halted"}, 32'(bus.halted_o), 32'(v.halted));
   endtask

   initial begin
      for (int i = 0; i < 16; i++) lut_mem[i] = 12'hA00 + 12'(i);
      lut_mem[3] = 12'h02C;
      lut_mem[5] = 12'h100;
      lut_mem[6] = 12'h007;
      lut_mem[7] = 12'hFFE;
      lut_mem[8] = 12'h009;
      lut_mem[9] = 12'h040;

      //            start halt stall br  jidx   pc       valid halted
      vecs[0]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 12'h000, 1'b0, 1'b0);
      vecs[1]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 12'h000, 1'b0, 1'b0);
      vecs[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 12'h000, 1'b0, 1'b0);
      vecs[3]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 12'h000, 1'b1, 1'b0);
      vecs[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 12'h001, 1'b1, 1'b0);
      vecs[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 12'h002, 1'b1, 1'b0);
      vecs[6]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 12'h003, 1'b1, 1'b0);
      vecs[7]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 12'h004, 1'b1, 1'b0);
      vecs[8]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 12'h005, 1'b1, 1'b0);
      vecs[9]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 12'h02C, 1'b1, 1'b0);
      vecs[10] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 12'h02D, 1'b1, 1'b0);
      vecs[11] = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd6, 12'h007, 1'b1, 1'b0);
      vecs[12] = mk(1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 12'h007, 1'b1, 1'b0);
      vecs[13] = mk(1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 12'h007, 1'b1, 1'b0);
      vecs[14] = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 12'h100, 1'b1, 1'b0);
      vecs[15] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 12'h101, 1'b1, 1'b0);
      vecs[16] = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 12'hFFE, 1'b1, 1'b0);
      vecs[17] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 12'hFFF, 1'b1, 1'b0);
      vecs[18] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 12'h000, 1'b1, 1'b0);
      vecs[19] = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd8, 12'h009, 1'b1, 1'b0);
      vecs[20] = mk(1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 12'h009, 1'b0, 1'b1);
      vecs[21] = mk(1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 12'h009, 1'b0, 1'b1);
      vecs[22] = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 12'h009, 1'b0, 1'b1);
      vecs[23] = mk(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 12'h009, 1'b0, 1'b1);
      vecs[24] = mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 12'h009, 1'b0, 1'b1);
      vecs[25] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 12'h009, 1'b0, 1'b1);
      vecs[26] = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 12'h000, 1'b1, 1'b0);
      vecs[27] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 12'h001, 1'b1, 1'b0);
      vecs[28] = mk(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 12'h001, 1'b0, 1'b1);
      vecs[29] = mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 12'h000, 1'b1, 1'b0);
      vecs[30] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 12'h001, 1'b1, 1'b0);

      bus.start_i = 1'b0; bus.halt_i = 1'b0; bus.stall_i = 1'b0;
      bus.branch_i = 1'b0; bus.jump_index_i = 4'd0; lut_x = 1'b1;

      #2;
      chk("reset pc", 32'(bus.pc_o), 32'h0);
      chk("reset valid", 32'(bus.pc_valid_o), 32'h0);
      chk("reset halted", 32'(bus.halted_o), 32'h0);
`ifdef BRANCH_PERF_EN
      chk("reset branch_cnt", 32'(bus.branch_cnt_o), 32'h0);
      chk("reset stall_cnt", 32'(bus.stall_cnt_o), 32'h0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 31; i++) apply(vecs[i], $sformatf("vec%0d", i));

`ifdef BRANCH_PERF_EN
      chk("table branch_cnt", 32'(bus.branch_cnt_o), 32'd5);
      chk("table stall_cnt", 32'(bus.stall_cnt_o), 32'd2);
`endif

      // Reach 0x040 in RUN, then drop reset between edges.
      apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd9, 12'h040, 1'b1, 1'b0), "to040");
`ifdef BRANCH_PERF_EN
      chk("pre-reset branch_cnt", 32'(bus.branch_cnt_o), 32'd6);
`endif
      #3;
      rst_n = 1'b0;
      #1;
      chk("async pc", 32'(bus.pc_o), 32'h0);
      chk("async valid", 32'(bus.pc_valid_o), 32'h0);
      chk("async halted", 32'(bus.halted_o), 32'h0);
`ifdef BRANCH_PERF_EN
      chk("async branch_cnt", 32'(bus.branch_cnt_o), 32'h0);
      chk("async stall_cnt", 32'(bus.stall_cnt_o), 32'h0);
`endif
      #2;
      rst_n = 1'b1;
      apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 12'h000, 1'b0, 1'b0), "post-reset idle");
      apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 12'h000, 1'b1, 1'b0), "post-reset start");
      apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 12'h001, 1'b1, 1'b0), "post-reset seq");

`ifdef BRANCH_PERF_EN
      // 4-bit counters saturate at 15.
      for (int i = 0; i < 20; i++)
         apply(mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 12'h001, 1'b1, 1'b0), $sformatf("sat_stall%0d", i));
      chk("sat stall_cnt", 32'(bus.stall_cnt_o), 32'd15);
      for (int i = 0; i < 18; i++)
         apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 12'h02C, 1'b1, 1'b0), $sformatf("sat_br%0d", i));
      chk("sat branch_cnt", 32'(bus.branch_cnt_o), 32'd15);
      chk("sat stall_cnt hold", 32'(bus.stall_cnt_o), 32'd15);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Program counter and fetch sequencer; the direct consumer of the 16-entry PC_LUT branch-target table.
- Holds the architectural PC, steps it sequentially and drives the LUT index from the branch field.
- Loads the LUT-provided target on a taken branch; handles stall, halt and restart.
- Output PC feeds instruction memory address.

Parameters:
PC_WIDTH, 12, width of PC and LUT target
RESET_PC, 0, PC value loaded on reset and on restart
PERF_WIDTH, 16, width of optional performance counters

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start_i  input  1  start/restart request (pulse)
halt_i  input  1  halt request from decode
stall_i  input  1  freeze PC this cycle
branch_i  input  1  taken branch/jump this cycle
jump_index_i  input  4  branch-target table index from instruction
lut_index_o  output  4  index to PC_LUT (combinational)
lut_target_i  input  PC_WIDTH  target returned by PC_LUT (combinational, same cycle)
pc_o  output  PC_WIDTH  current PC (registered)
pc_valid_o  output  1  pc_o is a live fetch address
halted_o  output  1  controller in HALT
branch_cnt_o  output  PERF_WIDTH  taken branches (only with BRANCH_PERF_EN)
stall_cnt_o  output  PERF_WIDTH  stalled RUN cycles (only with BRANCH_PERF_EN)

Behaviour:
- Clock and reset: single clock domain. rst_n low asynchronously forces:
  - state=IDLE, pc_o=RESET_PC, pc_valid_o=0, halted_o=0, counters=0.
- lut_index_o = jump_index_i, pure pass-through, at all times.
  - The LUT lookup and the PC update complete in the same cycle; there is no extra pipeline bubble.
- FSM states: IDLE, RUN, HALT.
  - IDLE: pc_o holds RESET_PC; pc_valid_o=0. start_i=1 -> RUN next cycle with pc_o=RESET_PC, pc_valid_o=1. All other inputs are ignored.
  - RUN: pc_valid_o=1. Per-cycle priority is halt_i > stall_i > branch_i > sequential:
    - halt_i=1 -> HALT; pc_o frozen at its current value.
    - else stall_i=1 -> pc_o unchanged; branch_i is ignored and must be held by the source until the stall clears.
    - else branch_i=1 -> pc_o <= lut_target_i.
    - else pc_o <= pc_o + 1, modulo 2^PC_WIDTH (all-ones wraps to 0, no flag).
  - HALT: halted_o=1, pc_valid_o=0, pc_o frozen. start_i=1 -> RUN with pc_o=RESET_PC (restart, not resume). halt_i, stall_i and branch_i are ignored.
  - start_i in RUN is ignored.
- Output timing:
  - halted_o and pc_valid_o are registered and change on the same edge as the state.
  - Latency from input to pc_o change: 1 cycle.
- Reset mid-operation: immediate return to the reset values above, regardless of state or pending branch.
- lut_target_i is sampled only when a branch is taken in RUN. X on lut_target_i at any other time must not propagate.

Optional Feature:
- Macro: BRANCH_PERF_EN.
- With the macro defined:
  - branch_cnt_o increments on every taken branch actually applied in RUN (not stalled, not halted).
  - stall_cnt_o increments on every RUN cycle with stall_i=1 and halt_i=0.
  - Both counters saturate at all-ones, clear on reset, and are not cleared by a restart.
- Without the macro: the counters and the ports branch_cnt_o/stall_cnt_o do not exist; all other behaviour is identical.

Test Plan:
- Reset/start: assert rst_n low, then release; hold IDLE 3 cycles -> pc_o=0, pc_valid_o=0. Pulse start_i -> next cycle pc_o=0, pc_valid_o=1; following cycles pc_o=1,2,3.
- Branch: in RUN at pc_o=5, branch_i=1, jump_index_i=4'd3, LUT entry 3 = 12'h02C -> lut_index_o=3 the same cycle; next cycle pc_o=12'h02C, then 12'h02D.
- Stall priority: at pc_o=7, stall_i=1 and branch_i=1 for 2 cycles, then stall_i=0 with branch_i still 1 (target 12'h100) -> pc_o stays 7 for 2 cycles, then becomes 12'h100. With BRANCH_PERF_EN: stall_cnt_o=2, branch_cnt_o=1.
- Wrap: PC_WIDTH=12, pc_o=12'hFFF, no branch/stall -> next pc_o=12'h000, pc_valid_o stays 1.
- Halt/restart: at pc_o=9, halt_i=1 together with branch_i=1 -> halted_o=1, pc_valid_o=0, pc_o=9 held for 5 cycles despite stall/branch toggling. Pulse start_i -> pc_o=0, halted_o=0, pc_valid_o=1.
- Async reset mid-run: at pc_o=12'h040 in RUN, drop rst_n between clock edges -> pc_o=0 and pc_valid_o=0 immediately, before the next edge; state IDLE after release.
